// File: rtl/vector_bitwise_pkg.sv
// Shared types and constants for the multi-beat vector bitwise/min-max unit.
//   alu_op_e      : operation encoding (codes above OP_MAX are illegal)
//   sew_e         : element width encoding
//   sew_bits()    : element width in bits for a given sew_e
//   AGNOSTIC_FILL : value written to agnostic tail/inactive elements
//   state_e       : sequencing states of the pipe
package vector_bitwise_pkg;

  localparam int MAX_VLEN = 512;

  typedef enum logic [4:0] {
    OP_AND  = 5'b00000,
    OP_OR   = 5'b00001,
    OP_XOR  = 5'b00010,
    OP_NOT  = 5'b00011,
    OP_MINU = 5'b00100,
    OP_MIN  = 5'b00101,
    OP_MAXU = 5'b00110,
    OP_MAX  = 5'b00111
  } alu_op_e;

  typedef enum logic [1:0] {
    SEW_8  = 2'b00,
    SEW_16 = 2'b01,
    SEW_32 = 2'b10,
    SEW_64 = 2'b11
  } sew_e;

  localparam logic [63:0] AGNOSTIC_FILL = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  function automatic int unsigned sew_bits(sew_e s);
    return 32'd8 << s;
  endfunction

endpackage

// File: rtl/vector_bitwise_pipe_if.sv
// Request/response bundle between the execute-stage issuer and the pipe.
//   master : issuer side (drives operation, operands, flush, result_ready)
//   slave  : pipe side (drives ready, result, result_valid, illegal_op)
interface vector_bitwise_pipe_if
  import vector_bitwise_pkg::*;
#(
  parameter int VLEN = MAX_VLEN
);
  logic                   start;
  logic                   ready;
  logic                   flush;
  logic [4:0]             bitwise_op;
  logic [1:0]             sew;
  logic [$clog2(VLEN):0]  vl;
  logic                   vm;
  logic                   ta;
  logic                   ma;
  logic [VLEN-1:0]        dataA;
  logic [VLEN-1:0]        dataB;
  logic [VLEN-1:0]        old_vd;
  logic [VLEN/8-1:0]      v0_mask;
  logic [VLEN-1:0]        result;
  logic                   result_valid;
  logic                   result_ready;
  logic                   illegal_op;

  modport master (
    output start, flush, bitwise_op, sew, vl, vm, ta, ma,
           dataA, dataB, old_vd, v0_mask, result_ready,
    input  ready, result, result_valid, illegal_op
  );

  modport slave (
    input  start, flush, bitwise_op, sew, vl, vm, ta, ma,
           dataA, dataB, old_vd, v0_mask, result_ready,
    output ready, result, result_valid, illegal_op
  );
endinterface

// File: rtl/vector_bitwise_lane.sv
// Combinational LANE_W-bit slice of the vector op, for every SEW.
//   a, b, old : operand A, operand B and prior destination bits of this slice
//   mask      : v0 bits for the slice's elements, bit j = element elem_base+j
//   elem_base : global index of the slice's first element
//   op, sew, vl, vm, ta, ma : latched operation controls
//   res       : slice result (B op A, or tail/inactive fill)
module vector_bitwise_lane
  import vector_bitwise_pkg::*;
#(
  parameter int VLEN   = MAX_VLEN,
  parameter int LANE_W = 128
) (
  input  logic [4:0]            op,
  input  sew_e                  sew,
  input  logic [$clog2(VLEN):0] vl,
  input  logic                  vm,
  input  logic                  ta,
  input  logic                  ma,
  input  logic [31:0]           elem_base,
  input  logic [LANE_W-1:0]     a,
  input  logic [LANE_W-1:0]     b,
  input  logic [LANE_W-1:0]     old,
  input  logic [LANE_W/8-1:0]   mask,
  output logic [LANE_W-1:0]     res
);

  int unsigned w, nel, vmax, vl_eff;
  logic [63:0] wmask, msb, ea, eb, eo, sa, sb, r;
  logic        mask_bit;

  always_comb begin
    w      = sew_bits(sew);
    nel    = 32'(LANE_W) >> (32'd3 + 32'(sew));
    vmax   = 32'(VLEN) >> (32'd3 + 32'(sew));
    vl_eff = (32'(vl) > vmax) ? vmax : 32'(vl);
    wmask  = (w == 32'd64) ? '1 : ((64'd1 << w) - 64'd1);
    msb    = wmask ^ (wmask >> 1);
    res    = '0;
    ea = '0; eb = '0; eo = '0; sa = '0; sb = '0; r = '0;
    mask_bit = 1'b0;
    for (int unsigned j = 0; j < LANE_W / 8; j++) begin
      if (j < nel) begin
        ea = 64'(a >> (j * w)) & wmask;
        eb = 64'(b >> (j * w)) & wmask;
        eo = 64'(old >> (j * w)) & wmask;
        // sign-extend to 64 bits so one signed compare serves every SEW
        sa = ((ea & msb) != '0) ? (ea | ~wmask) : ea;
        sb = ((eb & msb) != '0) ? (eb | ~wmask) : eb;
        mask_bit = 1'(mask >> j);
        case (op)
          OP_AND:  r = eb & ea;
          OP_OR:   r = eb | ea;
          OP_XOR:  r = eb ^ ea;
          OP_NOT:  r = ~eb;
          OP_MINU: r = (eb < ea) ? eb : ea;
          OP_MIN:  r = ($signed(sb) < $signed(sa)) ? eb : ea;
          OP_MAXU: r = (eb > ea) ? eb : ea;
          OP_MAX:  r = ($signed(sb) > $signed(sa)) ? eb : ea;
          default: r = eb;
        endcase
        if (elem_base + j >= vl_eff)
          r = ta ? AGNOSTIC_FILL : eo;
        else if (!vm && !mask_bit)
          r = ma ? AGNOSTIC_FILL : eo;
        res = res | (LANE_W'(r & wmask) << (j * w));
      end
    end
  end

endmodule

// File: rtl/vector_bitwise_pipe.sv
// Multi-beat vector bitwise/min-max unit. Latches an operation on
// start && ready, produces one LANE_W slice per cycle, then holds the
// assembled result until the consumer takes it.
//   clk, reset_n : clock, synchronous active-low reset
//   bus (slave)  : operation request, operands, flush and result handshake
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready=1, waiting for start
// BUSY    | one beat per cycle written into the result register
// DONE    | result_valid=1, held until result_ready
module vector_bitwise_pipe
  import vector_bitwise_pkg::*;
#(
  parameter int VLEN   = MAX_VLEN,
  parameter int LANE_W = 128
) (
  input  logic               clk,
  input  logic               reset_n,
  vector_bitwise_pipe_if.slave bus
);

  localparam int NBEATS = VLEN / LANE_W;
  localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int MASK_W = LANE_W / 8;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

  state_e state_q, state_d;
  logic [BEAT_W-1:0] beat_q;

  logic [4:0]                        op_q;
  sew_e                              sew_q;
  logic [$clog2(VLEN):0]             vl_q;
  logic                              vm_q, ta_q, ma_q, illegal_q;
  logic [NBEATS-1:0][LANE_W-1:0]     a_q, b_q, old_q, result_q;
  logic [VLEN/8-1:0]                 mask_q;

  logic              accept;
  logic [31:0]       elem_base;
  logic [MASK_W-1:0] lane_mask;
  logic [LANE_W-1:0] lane_res;

  // flush wins over a simultaneous start
  assign accept = bus.start && (state_q == ST_IDLE) && !bus.flush;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start)            state_d = ST_BUSY;
      ST_BUSY: if (beat_q == LAST_BEAT)  state_d = ST_DONE;
      ST_DONE: if (bus.result_ready)     state_d = ST_IDLE;
      default:                           state_d = ST_IDLE;
    endcase
    if (bus.flush) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      beat_q    <= '0;
      op_q      <= '0;
      sew_q     <= SEW_8;
      vl_q      <= '0;
      vm_q      <= 1'b0;
      ta_q      <= 1'b0;
      ma_q      <= 1'b0;
      illegal_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      old_q     <= '0;
      mask_q    <= '0;
      result_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q      <= bus.bitwise_op;
        sew_q     <= sew_e'(bus.sew);
        vl_q      <= bus.vl;
        vm_q      <= bus.vm;
        ta_q      <= bus.ta;
        ma_q      <= bus.ma;
        illegal_q <= (bus.bitwise_op > OP_MAX);
        a_q       <= bus.dataA;
        b_q       <= bus.dataB;
        old_q     <= bus.old_vd;
        mask_q    <= bus.v0_mask;
        beat_q    <= '0;
      end
      if (state_q == ST_BUSY && !bus.flush) begin
        result_q[beat_q] <= lane_res;
        beat_q           <= (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
      end
      if (bus.flush) beat_q <= '0;
    end
  end

  // elements per beat is LANE_W/SEW, a power of two
  assign elem_base = 32'(beat_q) * (32'(LANE_W) >> (32'd3 + 32'(sew_q)));
  assign lane_mask = MASK_W'(mask_q >> elem_base);

  vector_bitwise_lane #(.VLEN(VLEN), .LANE_W(LANE_W)) u_lane (
    .op        (op_q),
    .sew       (sew_q),
    .vl        (vl_q),
    .vm        (vm_q),
    .ta        (ta_q),
    .ma        (ma_q),
    .elem_base (elem_base),
    .a         (a_q[beat_q]),
    .b         (b_q[beat_q]),
    .old       (old_q[beat_q]),
    .mask      (lane_mask),
    .res       (lane_res)
  );

  assign bus.ready        = (state_q == ST_IDLE);
  assign bus.result_valid = (state_q == ST_DONE);
  assign bus.result       = result_q;
  assign bus.illegal_op   = (state_q == ST_DONE) && illegal_q;

endmodule

// File: tb/tb_vector_bitwise_pipe.sv
module tb_vector_bitwise_pipe;
  import vector_bitwise_pkg::*;

  localparam int VLEN   = 512;
  localparam int LANE_W = 128;
  localparam int NBEATS = VLEN / LANE_W;
  localparam int VL_W   = $clog2(VLEN) + 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  vector_bitwise_pipe_if #(.VLEN(VLEN)) bus ();

  vector_bitwise_pipe #(.VLEN(VLEN), .LANE_W(LANE_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Whole-vector reference: walk every element of the register directly.
  function automatic logic [VLEN-1:0] model(
    input logic [4:0] op, input logic [1:0] sew, input int vl,
    input logic vm, input logic ta, input logic ma,
    input logic [VLEN-1:0] a_v, input logic [VLEN-1:0] b_v,
    input logic [VLEN-1:0] o_v, input logic [VLEN/8-1:0] m_v);
    int w, nel, lim;
    logic [63:0] wm, a, b, o, r;
    longint sa, sb;
    logic [VLEN-1:0] res;
    w   = 8 << sew;
    nel = VLEN / w;
    lim = (vl > nel) ? nel : vl;
    wm  = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    res = '0;
    for (int e = 0; e < nel; e++) begin
      a  = 64'(a_v >> (e * w)) & wm;
      b  = 64'(b_v >> (e * w)) & wm;
      o  = 64'(o_v >> (e * w)) & wm;
      sa = $signed(a << (64 - w)) >>> (64 - w);
      sb = $signed(b << (64 - w)) >>> (64 - w);
      if (e >= lim)                  r = ta ? 64'hFFFF_FFFF_FFFF_FFFF : o;
      else if (!vm && !m_v[e])       r = ma ? 64'hFFFF_FFFF_FFFF_FFFF : o;
      else begin
        case (op)
          5'd0:    r = a & b;
          5'd1:    r = a | b;
          5'd2:    r = a ^ b;
          5'd3:    r = ~b;
          5'd4:    r = (a < b) ? a : b;
          5'd5:    r = (sa < sb) ? a : b;
          5'd6:    r = (a > b) ? a : b;
          5'd7:    r = (sa > sb) ? a : b;
          default: r = b;
        endcase
      end
      res = res | (VLEN'(r & wm) << (e * w));
    end
    return res;
  endfunction

  // Expected handshake: idle, then NBEATS busy cycles after accept, then done until taken.
  typedef enum {M_IDLE, M_BUSY, M_DONE} mphase_e;
  mphase_e         mph = M_IDLE;
  int              mcnt = 0;
  logic [VLEN-1:0] m_result = '0;
  logic            m_illegal = 1'b0;
  bit              cmp_en = 1'b0;

  always @(posedge clk) begin
    if (!reset_n) mph <= M_IDLE;
    else if (bus.flush) mph <= M_IDLE;
    else begin
      case (mph)
        M_IDLE: if (bus.start) begin
          m_result  <= model(bus.bitwise_op, bus.sew, int'(bus.vl), bus.vm, bus.ta, bus.ma,
                             bus.dataA, bus.dataB, bus.old_vd, bus.v0_mask);
          m_illegal <= (bus.bitwise_op > 5'd7);
          mcnt      <= NBEATS;
          mph       <= M_BUSY;
        end
        M_BUSY: begin
          mcnt <= mcnt - 1;
          if (mcnt == 1) mph <= M_DONE;
        end
        default: if (bus.result_ready) mph <= M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("ready", VLEN'(bus.ready), VLEN'(mph == M_IDLE));
      chk("result_valid", VLEN'(bus.result_valid), VLEN'(mph == M_DONE));
      if (mph == M_DONE) begin
        chk("result", bus.result, m_result);
        chk("illegal_op", VLEN'(bus.illegal_op), VLEN'(m_illegal));
      end
    end
  end

  task automatic set_op(input logic [4:0] op, input logic [1:0] sew, input int vl,
                        input logic vm, input logic ta, input logic ma,
                        input logic [VLEN-1:0] a, input logic [VLEN-1:0] b,
                        input logic [VLEN-1:0] o, input logic [VLEN/8-1:0] m);
    bus.bitwise_op = op;  bus.sew = sew;  bus.vl = VL_W'(vl);
    bus.vm = vm;  bus.ta = ta;  bus.ma = ma;
    bus.dataA = a;  bus.dataB = b;  bus.old_vd = o;  bus.v0_mask = m;
  endtask

  // Call just after a negedge with the DUT idle; returns at the first negedge with result_valid.
  task automatic run_op(output logic [VLEN-1:0] res, output int lat);
    int n = 0;
    bus.start = 1'b1;
    do begin
      @(negedge clk);
      bus.start = 1'b0;
      n++;
    end while (!bus.result_valid && n < 40);
    chk("valid_within_bound", VLEN'(bus.result_valid), VLEN'(1));
    lat = n;
    res = bus.result;
  endtask

  task automatic take_result();
    @(negedge clk);
    chk("ready_after_take", VLEN'(bus.ready), VLEN'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [VLEN-1:0] r;
    int lat;
    bus.start = 1'b0;  bus.flush = 1'b0;  bus.result_ready = 1'b1;
    set_op(5'd0, 2'd0, 0, 1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
    repeat (3) @(negedge clk);
    chk("rst_ready", VLEN'(bus.ready), VLEN'(1));
    chk("rst_valid", VLEN'(bus.result_valid), VLEN'(0));
    chk("rst_result", bus.result, '0);
    chk("rst_illegal", VLEN'(bus.illegal_op), VLEN'(0));
    reset_n = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);

    // SEW=8 AND, latency
    set_op(5'd0, 2'd0, 64, 1'b1, 1'b0, 1'b0, {64{8'h0F}}, {64{8'hFF}}, '0, '0);
    run_op(r, lat);
    chk("t1_and_result", r, {64{8'h0F}});
    chk("t1_latency", VLEN'(lat), VLEN'(5));
    take_result();

    // SEW=16 signed vs unsigned min
    set_op(5'd5, 2'd1, 32, 1'b1, 1'b0, 1'b0, {32{16'h0001}}, {32{16'h8000}}, '0, '0);
    run_op(r, lat);
    chk("t2_min", r, {32{16'h8000}});
    take_result();
    set_op(5'd4, 2'd1, 32, 1'b1, 1'b0, 1'b0, {32{16'h0001}}, {32{16'h8000}}, '0, '0);
    run_op(r, lat);
    chk("t2_minu", r, {32{16'h0001}});
    take_result();

    // SEW=32 XOR with tail undisturbed / agnostic
    set_op(5'd2, 2'd2, 5, 1'b1, 1'b0, 1'b0, {16{32'h12345678}}, {16{32'h0F0F0F0F}},
           {16{32'hDEADBEEF}}, '0);
    run_op(r, lat);
    chk("t3_tail_undisturbed", r, {{11{32'hDEADBEEF}}, {5{32'h1D3B5977}}});
    take_result();
    set_op(5'd2, 2'd2, 5, 1'b1, 1'b1, 1'b0, {16{32'h12345678}}, {16{32'h0F0F0F0F}},
           {16{32'hDEADBEEF}}, '0);
    run_op(r, lat);
    chk("t3_tail_agnostic", r, {{11{32'hFFFFFFFF}}, {5{32'h1D3B5977}}});
    take_result();

    // SEW=64 signed MAX under v0 mask, vl above VLEN/SEW
    set_op(5'd7, 2'd3, 64, 1'b0, 1'b0, 1'b0, {8{64'h5}}, {8{64'hFFFF_FFFF_FFFF_FFFF}},
           {8{64'h1111_1111_1111_1111}}, 64'hAA);
    run_op(r, lat);
    chk("t4_masked_max", r, {4{64'h5, 64'h1111_1111_1111_1111}});
    take_result();

    // vl=0: whole result is tail
    set_op(5'd3, 2'd1, 0, 1'b1, 1'b1, 1'b0, {32{16'h1234}}, {32{16'h5678}}, '0, '0);
    run_op(r, lat);
    chk("vl0_agnostic", r, {VLEN{1'b1}});
    take_result();
    set_op(5'd1, 2'd0, 0, 1'b1, 1'b0, 1'b1, {64{8'h12}}, {64{8'h34}}, {64{8'hA5}}, '0);
    run_op(r, lat);
    chk("vl0_undisturbed", r, {64{8'hA5}});
    take_result();

    // Model-only vectors: mixed signs, partial vl, mask agnostic, clamp
    set_op(5'd7, 2'd0, 40, 1'b0, 1'b0, 1'b1, {16{32'h807F01FE}}, {16{32'h7F80FE01}},
           {16{32'h0BADF00D}}, 64'hF0F0_3C3C_A5A5_0FF0);
    run_op(r, lat);
    take_result();
    set_op(5'd6, 2'd0, 70, 1'b1, 1'b0, 1'b0, {16{32'h807F01FE}}, {16{32'h7F80FE01}}, '0, '0);
    run_op(r, lat);
    take_result();
    set_op(5'd4, 2'd3, 3, 1'b0, 1'b1, 1'b0, {8{64'h8000_0000_0000_0001}},
           {8{64'h7FFF_0000_0000_0000}}, {8{64'h2222_2222_2222_2222}}, 64'h05);
    run_op(r, lat);
    take_result();

    // Backpressure: result held, second start ignored
    bus.result_ready = 1'b0;
    set_op(5'd1, 2'd0, 64, 1'b1, 1'b0, 1'b0, {64{8'hF0}}, {64{8'h0C}}, '0, '0);
    run_op(r, lat);
    chk("bp_first_result", r, {64{8'hFC}});
    for (int i = 0; i < 10; i++) begin
      if (i == 2) begin
        set_op(5'd0, 2'd0, 64, 1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
        bus.start = 1'b1;
      end
      if (i == 5) bus.start = 1'b0;
      @(negedge clk);
      chk("bp_result_stable", bus.result, {64{8'hFC}});
      chk("bp_not_ready", VLEN'(bus.ready), VLEN'(0));
    end
    bus.result_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_rises", VLEN'(bus.ready), VLEN'(1));
    chk("bp_valid_drops", VLEN'(bus.result_valid), VLEN'(0));

    // Flush during beat 2
    set_op(5'd0, 2'd2, 16, 1'b1, 1'b0, 1'b0, {16{32'hFFFF0000}}, {16{32'h0000FFFF}}, '0, '0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_ready", VLEN'(bus.ready), VLEN'(1));
    for (int i = 0; i < 8; i++) begin
      chk("flush_no_valid", VLEN'(bus.result_valid), VLEN'(0));
      @(negedge clk);
    end

    // Illegal op code
    set_op(5'b01000, 2'd2, 16, 1'b1, 1'b0, 1'b0, {16{32'h13579BDF}}, {16{32'hCAFEF00D}}, '0, '0);
    run_op(r, lat);
    chk("illegal_result", r, {16{32'hCAFEF00D}});
    chk("illegal_flag", VLEN'(bus.illegal_op), VLEN'(1));
    take_result();

    // Reset in the middle of an operation
    set_op(5'd2, 2'd0, 64, 1'b1, 1'b0, 1'b0, {64{8'h3C}}, {64{8'hC3}}, '0, '0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("midrst_ready", VLEN'(bus.ready), VLEN'(1));
    chk("midrst_result", bus.result, '0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrst_no_valid", VLEN'(bus.result_valid), VLEN'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
